// File: rtl/tinycpu_decode_pkg.sv
// Shared types for the decode stage: instruction classes, opcodes, FSM states
// and the decoded bundle that travels from the field decoder to the execute port.
package tinycpu_decode_pkg;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    localparam logic [5:0] OP_LOAD  = 6'h20;
    localparam logic [5:0] OP_STORE = 6'h21;
    localparam logic [5:0] OP_BEQ   = 6'h22;
    localparam logic [5:0] OP_BNE   = 6'h23;
    localparam logic [5:0] OP_JUMP  = 6'h30;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic {
        IN_WAIT  = 1'b0,
        IN_ACKED = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_VALID = 2'd1,
        OUT_DRAIN = 2'd2
    } out_state_e;

    typedef struct packed {
        cls_e        cls;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] imm;
    } dec_bundle_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational decode of one 32-bit instruction word into class,
// ALU op, register fields and extended immediate.
module instr_field_decoder
    import tinycpu_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t dec_o
);

    logic [5:0] op;
    assign op = instr[31:26];

    always_comb begin
        dec_o        = '0;
        dec_o.cls    = CLS_ILLEGAL;
        dec_o.rd     = instr[25:21];
        dec_o.ra     = instr[20:16];
        dec_o.rb     = instr[15:11];

        if (op[5:4] == 2'b00) begin
            dec_o.cls    = CLS_ALU_R;
            dec_o.alu_op = op[3:0];
        end else if (op[5:4] == 2'b01) begin
            dec_o.cls    = CLS_ALU_I;
            dec_o.alu_op = op[3:0];
            // Logical immediates (op[3] set) are zero-extended, arithmetic ones sign-extended
            dec_o.imm    = op[3] ? {16'h0000, instr[15:0]} : sext16(instr[15:0]);
        end else begin
            case (op)
                OP_LOAD: begin
                    dec_o.cls = CLS_LOAD;
                    dec_o.imm = sext16(instr[15:0]);
                end
                OP_STORE: begin
                    dec_o.cls = CLS_STORE;
                    dec_o.imm = sext16(instr[15:0]);
                end
                OP_BEQ, OP_BNE: begin
                    dec_o.cls    = CLS_BRANCH;
                    dec_o.alu_op = {3'b000, op[0]};
                    dec_o.imm    = sext16(instr[15:0]);
                end
                OP_JUMP: begin
                    dec_o.cls = CLS_JUMP;
                    dec_o.imm = sext26(instr[25:0]);
                end
                OP_HALT: begin
                    dec_o.cls = CLS_HALT;
                end
                default: begin
                    dec_o.cls = CLS_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: one-word hold register fed by the fetch handshake, registered
// decoded bundle presented to execute, with issue sequence and illegal-op counters.
module instr_decode_stage
    import tinycpu_decode_pkg::*;
#(
    parameter int SEQ_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_DOR,
    input  logic [31:0]          fetch_data,
    output logic                 ack_to_fetch,
    output logic                 dec_DOR,
    input  logic                 ack_from_exec,
    output logic [2:0]           dec_class,
    output logic [3:0]           dec_alu_op,
    output logic [4:0]           dec_rd,
    output logic [4:0]           dec_ra,
    output logic [4:0]           dec_rb,
    output logic [31:0]          dec_imm,
    output logic [SEQ_WIDTH-1:0] dec_seq,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    in_state_e            in_state_q,  in_state_d;
    out_state_e           out_state_q, out_state_d;
    logic                 ack_q,       ack_d;
    logic [31:0]          hold_q,      hold_d;
    logic                 full_q,      full_d;
    dec_bundle_t          dec_q,       dec_d;
    logic                 dec_dor_q,   dec_dor_d;
    logic [SEQ_WIDTH-1:0] seq_q,       seq_d;
    logic [SEQ_WIDTH-1:0] dec_seq_q,   dec_seq_d;
    logic [CNT_WIDTH-1:0] illegal_q,   illegal_d;
    dec_bundle_t          field_dec;

    instr_field_decoder u_field_decoder (
        .instr (hold_q),
        .dec_o (field_dec)
    );

    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        ack_d       = 1'b0;
        hold_d      = hold_q;
        full_d      = full_q;
        dec_d       = dec_q;
        dec_dor_d   = dec_dor_q;
        seq_d       = seq_q;
        dec_seq_d   = dec_seq_q;
        illegal_d   = illegal_q;

        // Capture only looks at the registered full flag, so a transfer that
        // empties the hold register is seen by capture one edge later.
        unique case (in_state_q)
            IN_WAIT: begin
                if (fetch_DOR && !full_q) begin
                    hold_d     = fetch_data;
                    full_d     = 1'b1;
                    ack_d      = 1'b1;
                    in_state_d = IN_ACKED;
                end
            end
            IN_ACKED: begin
                if (!fetch_DOR) begin
                    in_state_d = IN_WAIT;
                end
            end
            default: in_state_d = IN_WAIT;
        endcase

        unique case (out_state_q)
            OUT_IDLE: begin
                if (full_q) begin
                    dec_d       = field_dec;
                    dec_seq_d   = seq_q;
                    seq_d       = seq_q + SEQ_WIDTH'(1);
                    full_d      = 1'b0;
                    dec_dor_d   = 1'b1;
                    out_state_d = OUT_VALID;
                    if (field_dec.cls == CLS_ILLEGAL && illegal_q != '1) begin
                        illegal_d = illegal_q + CNT_WIDTH'(1);
                    end
                end
            end
            OUT_VALID: begin
                if (ack_from_exec) begin
                    dec_dor_d   = 1'b0;
                    out_state_d = OUT_DRAIN;
                end
            end
            OUT_DRAIN: begin
                if (!ack_from_exec) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_state_q  <= IN_WAIT;
            out_state_q <= OUT_IDLE;
            ack_q       <= 1'b0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            dec_q       <= '0;
            dec_dor_q   <= 1'b0;
            seq_q       <= '0;
            dec_seq_q   <= '0;
            illegal_q   <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            ack_q       <= ack_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            dec_q       <= dec_d;
            dec_dor_q   <= dec_dor_d;
            seq_q       <= seq_d;
            dec_seq_q   <= dec_seq_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ack_to_fetch  = ack_q;
    assign dec_DOR       = dec_dor_q;
    assign dec_class     = dec_q.cls;
    assign dec_alu_op    = dec_q.alu_op;
    assign dec_rd        = dec_q.rd;
    assign dec_ra        = dec_q.ra;
    assign dec_rb        = dec_q.rb;
    assign dec_imm       = dec_q.imm;
    assign dec_seq       = dec_seq_q;
    assign illegal_count = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: fetch/execute handshakes driven
// step by step, every decoded field compared against hand-derived values.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_DOR;
    logic [31:0] fetch_data;
    logic        ack_to_fetch;
    logic        dec_DOR;
    logic        ack_from_exec;
    logic [2:0]  dec_class;
    logic [3:0]  dec_alu_op;
    logic [4:0]  dec_rd, dec_ra, dec_rb;
    logic [31:0] dec_imm;
    logic [7:0]  dec_seq;
    logic [15:0] illegal_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.SEQ_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_DOR     (fetch_DOR),
        .fetch_data    (fetch_data),
        .ack_to_fetch  (ack_to_fetch),
        .dec_DOR       (dec_DOR),
        .ack_from_exec (ack_from_exec),
        .dec_class     (dec_class),
        .dec_alu_op    (dec_alu_op),
        .dec_rd        (dec_rd),
        .dec_ra        (dec_ra),
        .dec_rb        (dec_rb),
        .dec_imm       (dec_imm),
        .dec_seq       (dec_seq),
        .illegal_count (illegal_count)
    );

    // Word, class, alu_op, imm, {rd,ra,rb} for the decode-rule table
    logic [31:0] ext_word [9] = '{32'h14221234, 32'h6000FFFF, 32'h8000FFFF, 32'h84007FFF,
                                  32'h8800FFFC, 32'h8C000004, 32'hC3FFFFFF, 32'hFC001234,
                                  32'h48008000};
    logic [2:0]  ext_cls  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd1};
    logic [3:0]  ext_op   [9] = '{4'd5, 4'd8, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd2};
    logic [31:0] ext_imm  [9] = '{32'h00000000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00007FFF,
                                  32'hFFFFFFFC, 32'h00000004, 32'hFFFFFFFF, 32'h00000000,
                                  32'hFFFF8000};
    logic [14:0] ext_regs [9] = '{{5'd1, 5'd2, 5'd2}, {5'd0, 5'd0, 5'd31}, {5'd0, 5'd0, 5'd31},
                                  {5'd0, 5'd0, 5'd15}, {5'd0, 5'd0, 5'd31}, {5'd0, 5'd0, 5'd0},
                                  {5'd31, 5'd31, 5'd31}, {5'd0, 5'd0, 5'd2}, {5'd0, 5'd0, 5'd16}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; drop fetch_DOR once acked (or after max_cycles) and idle one cycle
    task automatic fetch_word(input logic [31:0] w, input int max_cycles, output bit got);
        got        = 1'b0;
        fetch_data = w;
        fetch_DOR  = 1'b1;
        for (int i = 0; i < max_cycles && !got; i++) begin
            step();
            if (ack_to_fetch === 1'b1) got = 1'b1;
        end
        fetch_DOR = 1'b0;
        step();
    endtask

    task automatic expect_fetch(input string nm, input logic [31:0] w);
        bit got;
        fetch_word(w, 10, got);
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL %s_ack: got %0b expected 1", nm, got);
        end
    endtask

    // Wait for a bundle, compare every field, then ack it for one cycle
    task automatic receive(input string nm, input logic [2:0] ecls, input logic [3:0] eop,
                           input logic [31:0] eimm, input logic [14:0] eregs,
                           input logic [7:0] eseq);
        int n = 0;
        while (dec_DOR !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (dec_DOR !== 1'b1) begin
            failures++;
            $display("FAIL %s_dor_timeout: got %b expected 1", nm, dec_DOR);
        end
        checks++;
        if (dec_class !== ecls) begin
            failures++;
            $display("FAIL %s_class: got %0d expected %0d", nm, dec_class, ecls);
        end
        checks++;
        if (dec_alu_op !== eop) begin
            failures++;
            $display("FAIL %s_alu_op: got %0d expected %0d", nm, dec_alu_op, eop);
        end
        checks++;
        if (dec_imm !== eimm) begin
            failures++;
            $display("FAIL %s_imm: got %h expected %h", nm, dec_imm, eimm);
        end
        checks++;
        if ({dec_rd, dec_ra, dec_rb} !== eregs) begin
            failures++;
            $display("FAIL %s_regs: got %h expected %h", nm, {dec_rd, dec_ra, dec_rb}, eregs);
        end
        checks++;
        if (dec_seq !== eseq) begin
            failures++;
            $display("FAIL %s_seq: got %0d expected %0d", nm, dec_seq, eseq);
        end
        ack_from_exec = 1'b1;
        step();
        ack_from_exec = 1'b0;
        checks++;
        if (dec_DOR !== 1'b0) begin
            failures++;
            $display("FAIL %s_dor_drop: got %b expected 0", nm, dec_DOR);
        end
        step();
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({ack_to_fetch, dec_DOR, dec_class, dec_alu_op, dec_rd, dec_ra, dec_rb,
             dec_imm, dec_seq, illegal_count} !== '0) begin
            failures++;
            $display("FAIL %s: got ack=%b dor=%b cls=%0d op=%0d regs=%h imm=%h seq=%0d ill=%0d expected all 0",
                     nm, ack_to_fetch, dec_DOR, dec_class, dec_alu_op,
                     {dec_rd, dec_ra, dec_rb}, dec_imm, dec_seq, illegal_count);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        fetch_DOR     = 1'b1;
        fetch_data    = 32'h50221234;
        ack_from_exec = 1'b0;
        step();
        step();
        check_all_zero("reset");
        fetch_DOR = 1'b0;
        reset     = 1'b1;
        step();
        check_all_zero("reset_release");
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    // 0x50221234: opcode 0x14 (ALU_I, op[3]=0 -> sign-ext), rd=1 ra=2 rb=2
    task automatic test_single_word();
        fetch_data = 32'h50221234;
        fetch_DOR  = 1'b1;
        step();
        checks++;
        if (ack_to_fetch !== 1'b1) begin
            failures++;
            $display("FAIL single_ack_pulse: got %b expected 1", ack_to_fetch);
        end
        checks++;
        if (dec_DOR !== 1'b0) begin
            failures++;
            $display("FAIL single_dor_early: got %b expected 0", dec_DOR);
        end
        step();
        checks++;
        if (ack_to_fetch !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_width: got %b expected 0", ack_to_fetch);
        end
        checks++;
        if (dec_DOR !== 1'b1) begin
            failures++;
            $display("FAIL single_dor_latency: got %b expected 1", dec_DOR);
        end
        step();
        checks++;
        if (ack_to_fetch !== 1'b0) begin
            failures++;
            $display("FAIL single_no_recapture: got %b expected 0", ack_to_fetch);
        end
        fetch_DOR = 1'b0;
        receive("single", 3'd1, 4'd4, 32'h00001234, {5'd1, 5'd2, 5'd2}, 8'd0);
        step();
        checks++;
        if (dec_DOR !== 1'b0) begin
            failures++;
            $display("FAIL single_no_stale: got %b expected 0", dec_DOR);
        end
        $display("test_single_word done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_extension();
        for (int i = 0; i < 9; i++) begin
            expect_fetch($sformatf("ext%0d", i), ext_word[i]);
            receive($sformatf("ext%0d", i), ext_cls[i], ext_op[i], ext_imm[i], ext_regs[i], 8'(i + 1));
            $display("ext word %h -> cls=%0d op=%0d imm=%h", ext_word[i], dec_class, dec_alu_op, dec_imm);
        end
    endtask

    // Seq continues at 10 after the single word and the nine-word table
    task automatic test_back_pressure();
        bit got;
        expect_fetch("bp_w0", 32'h50221234);
        expect_fetch("bp_w1", 32'h84007FFF);
        fetch_word(32'h8C000004, 6, got);
        checks++;
        if (got !== 1'b0) begin
            failures++;
            $display("FAIL bp_w2_not_acked: got %b expected 0", got);
        end
        checks++;
        if (dec_DOR !== 1'b1 || dec_seq !== 8'd10 || dec_imm !== 32'h00001234) begin
            failures++;
            $display("FAIL bp_stall_bundle: got dor=%b seq=%0d imm=%h expected dor=1 seq=10 imm=00001234",
                     dec_DOR, dec_seq, dec_imm);
        end
        receive("bp_w0", 3'd1, 4'd4, 32'h00001234, {5'd1, 5'd2, 5'd2}, 8'd10);
        receive("bp_w1", 3'd3, 4'd0, 32'h00007FFF, {5'd0, 5'd0, 5'd15}, 8'd11);
        expect_fetch("bp_w2", 32'h8C000004);
        receive("bp_w2", 3'd4, 4'd1, 32'h00000004, {5'd0, 5'd0, 5'd0}, 8'd12);
        $display("test_back_pressure done checks=%0d failures=%0d", checks, failures);
    endtask

    // 0xE8A55A5A: opcode 0x3A (unassigned), rd=5 ra=5 rb=11
    task automatic test_illegal_wrap();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 258; i++) begin
            expect_fetch("ill", 32'hE8A55A5A);
            receive("ill", 3'd7, 4'd0, 32'h0, {5'd5, 5'd5, 5'd11}, 8'(i));
        end
        checks++;
        if (illegal_count !== 16'd258) begin
            failures++;
            $display("FAIL illegal_count: got %0d expected 258", illegal_count);
        end
        $display("test_illegal_wrap done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_op();
        expect_fetch("mid_w0", 32'h50221234);
        expect_fetch("mid_w1", 32'h84007FFF);
        checks++;
        if (dec_DOR !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_dor: got %b expected 1", dec_DOR);
        end
        reset = 1'b0;
        step();
        check_all_zero("mid_reset");
        reset = 1'b1;
        step();
        step();
        checks++;
        if (dec_DOR !== 1'b0 || ack_to_fetch !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_stale: got dor=%b ack=%b expected 0 0", dec_DOR, ack_to_fetch);
        end
        expect_fetch("mid_new", 32'h6000FFFF);
        receive("mid_new", 3'd1, 4'd8, 32'h0000FFFF, {5'd0, 5'd0, 5'd31}, 8'd0);
        checks++;
        if (illegal_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_illegal_count: got %0d expected 0", illegal_count);
        end
        $display("test_reset_mid_op done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_extension();
        test_back_pressure();
        test_illegal_wrap();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
